accumulator_sequencer: RTL
==========================

Name: accumulator_sequencer

Overview:
- Parametrised successor of the accumulator write/read controller for the systolic MAC array.
- Launched by a start pulse with tile dimensions; waits out array fill; generates diagonal-skewed ramp-up, full-width and ramp-down lane masks.
- Drives accumulator write/read addresses in overwrite or accumulate mode, honours MAC pipeline stalls and pulses done.
- Sits between the MAC array control and the accumulator SRAM bank.

Parameters:
- MUL_SIZE, 32, systolic array edge = number of accumulator lanes; power of two, 4..64.
- ADDR_W, 10, accumulator row address width.
- DIM_W, 7, width of the V/U dimension inputs.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  synchronous active-high reset.
- start_i  in  1  launch pulse; sampled only in IDLE.
- V_dim_i  in  DIM_W  V dimension; latched at accepted start.
- U_dim_i  in  DIM_W  U dimension; latched at accepted start.
- accumulate_i  in  1  1 = read-add-write, 0 = overwrite; latched at start.
- stall_i  in  1  MAC pipeline stall; freezes sequencing.
- busy_o  out  1  high from accepted start until done_o cycle inclusive.
- write_accumulator_o  out  1  write strobe.
- read_accumulator_o  out  1  read strobe (accumulate mode only).
- accumulator_addr_wr_o  out  ADDR_W  write row address.
- accumulator_addr_rd_o  out  ADDR_W  read row address.
- accum_addr_mask_o  out  MUL_SIZE  lane enable; MSB = lane 0.
- accumulator_add_o  out  1  adder select to accumulator bank.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  one-cycle pulse, coincident with done_o, on rejected job.

Behaviour:
- Reset: synchronous; every output 0, state IDLE, counters 0. rst_i mid-job aborts without done_o; IDLE on the following cycle.
- All outputs registered.
- Derived values at start:
  - T = (V_dim_i >> log2(MUL_SIZE)) * (U_dim_i >> log2(MUL_SIZE)).
  - N = T * MUL_SIZE.
  - W = N + MUL_SIZE - 1 (write cycles).
- States: IDLE -> FILL -> WRITE -> DONE -> IDLE.
- IDLE:
  - start_i=1: latch dims and mode, busy_o=1.
  - T==0 or W > 2^ADDR_W: go to DONE directly with err_o, no writes.
  - Otherwise go to FILL.
- FILL: counts MUL_SIZE non-stalled cycles, then WRITE.
- WRITE: write counter c runs 0..W-1, one step per non-stalled cycle.
  - write_accumulator_o=1.
  - accumulator_addr_wr_o = c.
  - Lane j enabled iff j <= c and c-j < N.
  - Ramp-up: c=0 gives mask MSB only; c=MUL_SIZE-1 gives all ones.
  - Ramp-down: c=N gives all but MSB; c=W-1 gives LSB only.
  - Accumulate mode: read_accumulator_o=1, accumulator_addr_rd_o = c, same mask; accumulator_add_o=1 for the whole job.
  - Overwrite mode: read_accumulator_o=0, accumulator_add_o=0.
- DONE: done_o=1 (plus err_o if rejected) for one cycle, then IDLE; busy_o drops the cycle after.
- Stall: stall_i=1 in FILL/WRITE freezes counters, addresses and mask; write/read strobes forced 0 that cycle. Resume continues at the same c with no skipped or repeated rows.
- Simultaneous stall and final count: the final write occurs only on a non-stalled cycle.
- start_i while busy_o=1: ignored.
- start_i in the DONE cycle: ignored.
- Latency (no stalls), start accepted at cycle 0:
  - FILL occupies cycles 1..MUL_SIZE.
  - Writes occupy cycles MUL_SIZE+1..MUL_SIZE+W.
  - done_o at MUL_SIZE+W+1.
- Arithmetic: T computed at full width before the ADDR_W comparison; the address never wraps.

Optional Feature:
- Macro ACC_SEQ_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_busy_cycles_o[15:0] and perf_stall_cycles_o[15:0].
  - Both cleared at accepted start.
  - Busy counter counts every cycle with busy_o=1.
  - Stall counter counts stall_i=1 cycles in FILL/WRITE.
  - Both saturate at 16'hFFFF and hold after done.
  - Reset clears both.
- Undefined: ports and counters absent; remaining behaviour identical.

Test Plan:
- Job with MUL_SIZE=32, V=32, U=32, overwrite, start at cycle 0 -> writes cycles 33..95, addr 0..62. Masks 0x80000000 at addr 0, 0xFFFFFFFF at addr 31, 0x7FFFFFFF at addr 32, 0x00000001 at addr 62. done_o at 96, read/add strobes never high.
- V=64, U=64, accumulate -> N=128, 159 writes. rd addr = wr addr each write, accumulator_add_o=1 throughout. Mask all ones for addr 31..127.
- Same job as the first, stall_i high for 5 cycles at c=40 -> strobes low for 5 cycles, addr holds 40. Total writes still 63, done_o at 101. With ACC_SEQ_PERF_CNT_EN: stall count 5, busy count 102.
- V=16, U=64 -> T=0: done_o and err_o pulse at cycle 1, no writes. With ADDR_W=6, V=U=64 (W=159 > 64) -> same error pulse, no writes.
- rst_i asserted at c=20 -> all outputs 0 next cycle, no done_o. A new start_i 2 cycles later runs a full clean job from addr 0.
- start_i pulsed at c=10 mid-job -> ignored, job completes unchanged, single done_o.

Source files
------------

// File: rtl/accumulator_sequencer.sv
// ---------------------------------------------------------------------------
// accumulator_sequencer
//
// Accumulator write/read sequencer for a MUL_SIZE x MUL_SIZE systolic MAC
// array. A start pulse launches a job: the sequencer waits MUL_SIZE cycles
// for the array to fill, then walks the accumulator rows 0..W-1. It emits a
// diagonal lane mask (ramp-up, full width, ramp-down) for each row and, in
// accumulate mode, a matching read strobe. A MAC pipeline stall freezes the
// sequencing. A one-cycle done pulse ends every job, with err on rejected jobs.
//
// Derived per job: T = (V >> log2(MUL_SIZE)) * (U >> log2(MUL_SIZE)),
//                  N = T * MUL_SIZE, W = N + MUL_SIZE - 1.
// A job is rejected when T == 0 or W > 2^ADDR_W.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   start_i                      launch pulse (sampled in IDLE only)
//   V_dim_i, U_dim_i             tile dimensions, latched at start
//   accumulate_i                 1 = read-add-write, 0 = overwrite
//   stall_i                      MAC pipeline stall
//   busy_o                       accepted start .. done cycle inclusive
//   write_accumulator_o          write strobe
//   read_accumulator_o           read strobe (accumulate mode)
//   accumulator_addr_wr_o/_rd_o  row addresses
//   accum_addr_mask_o            lane enables, MSB = lane 0
//   accumulator_add_o            adder select for the whole job
//   done_o, err_o                completion / rejection pulses
//
// Optional build macro ACC_SEQ_PERF_CNT_EN adds perf_busy_cycles_o and
// perf_stall_cycles_o (16-bit saturating counters).
// All outputs are registered.
// ---------------------------------------------------------------------------
module accumulator_sequencer #(
    parameter int MUL_SIZE = 32,
    parameter int ADDR_W   = 10,
    parameter int DIM_W    = 7
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [DIM_W-1:0]    V_dim_i,
    input  logic [DIM_W-1:0]    U_dim_i,
    input  logic                accumulate_i,
    input  logic                stall_i,
    output logic                busy_o,
    output logic                write_accumulator_o,
    output logic                read_accumulator_o,
    output logic [ADDR_W-1:0]   accumulator_addr_wr_o,
    output logic [ADDR_W-1:0]   accumulator_addr_rd_o,
    output logic [MUL_SIZE-1:0] accum_addr_mask_o,
    output logic                accumulator_add_o,
    output logic                done_o,
    output logic                err_o
`ifdef ACC_SEQ_PERF_CNT_EN
    ,
    output logic [15:0]         perf_busy_cycles_o,
    output logic [15:0]         perf_stall_cycles_o
`endif
);

    localparam int LOG2_MS = $clog2(MUL_SIZE);
    // Wide enough for the full T/N/W arithmetic and for 2^ADDR_W, so the
    // rejection compare never sees a truncated value.
    localparam int CW = (2 * DIM_W + 2 > ADDR_W + 2) ? (2 * DIM_W + 2) : (ADDR_W + 2);
    localparam logic [CW-1:0] FILL_LAST = CW'(MUL_SIZE - 1);
    localparam logic [CW-1:0] ADDR_SPAN = CW'(1) << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;          // fill counter in FILL, row c in WRITE
    logic [CW-1:0]       n_q, n_d;
    logic [CW-1:0]       w_last_q, w_last_d;    // W - 1, the final row
    logic                acc_q, acc_d;
    logic                busy_q, busy_d;
    logic                wr_q, wr_d;
    logic                rd_q, rd_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [MUL_SIZE-1:0] mask_q, mask_d;
    logic                add_q, add_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic [CW-1:0]       v_tiles, u_tiles, t_calc, n_calc, w_calc;
    logic [CW-1:0]       row_next;
    logic [MUL_SIZE-1:0] mask_next;
    logic                reject;
    logic                accept;

    assign v_tiles = CW'(V_dim_i >> LOG2_MS);
    assign u_tiles = CW'(U_dim_i >> LOG2_MS);
    assign t_calc  = v_tiles * u_tiles;
    assign n_calc  = t_calc << LOG2_MS;
    assign w_calc  = n_calc + FILL_LAST;
    assign reject  = (t_calc == '0) || (w_calc > ADDR_SPAN);
    assign accept  = (state_q == S_IDLE) && start_i;

    // Row that the next non-stalled cycle will present: row 0 when leaving
    // FILL, c+1 while walking rows.
    assign row_next = (state_q == S_WRITE) ? (cnt_q + CW'(1)) : '0;

    // Lane j is active on row c when the diagonal wavefront has reached it
    // (j <= c) and has not yet passed the last of its N rows (c - j < N).
    generate
        for (genvar gi = 0; gi < MUL_SIZE; gi++) begin : g_lane
            assign mask_next[MUL_SIZE-1-gi] = (row_next >= CW'(gi)) &&
                                              ((row_next - CW'(gi)) < n_q);
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        n_d      = n_q;
        w_last_d = w_last_q;
        acc_d    = acc_q;
        busy_d   = busy_q;
        wr_d     = 1'b0;
        rd_d     = 1'b0;
        addr_d   = addr_q;
        mask_d   = mask_q;
        add_d    = add_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                add_d  = 1'b0;
                addr_d = '0;
                mask_d = '0;
                cnt_d  = '0;
                if (start_i) begin
                    busy_d   = 1'b1;
                    acc_d    = accumulate_i;
                    n_d      = n_calc;
                    w_last_d = w_calc - CW'(1);
                    if (reject) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_FILL;
                        add_d   = accumulate_i;
                    end
                end
            end

            S_FILL: begin
                if (!stall_i) begin
                    if (cnt_q == FILL_LAST) begin
                        state_d = S_WRITE;
                        cnt_d   = '0;
                        wr_d    = 1'b1;
                        rd_d    = acc_q;
                        addr_d  = '0;
                        mask_d  = mask_next;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            S_WRITE: begin
                // A stalled cycle keeps address and mask and drops the strobes,
                // so the row after the stall is exactly c+1.
                if (!stall_i) begin
                    if (cnt_q == w_last_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        addr_d  = '0;
                        mask_d  = '0;
                    end else begin
                        cnt_d  = row_next;
                        wr_d   = 1'b1;
                        rd_d   = acc_q;
                        addr_d = row_next[ADDR_W-1:0];
                        mask_d = mask_next;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                add_d   = 1'b0;
                cnt_d   = '0;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            n_q      <= '0;
            w_last_q <= '0;
            acc_q    <= 1'b0;
            busy_q   <= 1'b0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            addr_q   <= '0;
            mask_q   <= '0;
            add_q    <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            n_q      <= n_d;
            w_last_q <= w_last_d;
            acc_q    <= acc_d;
            busy_q   <= busy_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            addr_q   <= addr_d;
            mask_q   <= mask_d;
            add_q    <= add_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign busy_o                = busy_q;
    assign write_accumulator_o   = wr_q;
    assign read_accumulator_o    = rd_q;
    assign accumulator_addr_wr_o = addr_q;
    assign accumulator_addr_rd_o = addr_q;
    assign accum_addr_mask_o     = mask_q;
    assign accumulator_add_o     = add_q;
    assign done_o                = done_q;
    assign err_o                 = err_q;

`ifdef ACC_SEQ_PERF_CNT_EN
    logic [15:0] perf_busy_q, perf_busy_d;
    logic [15:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_busy_d  = perf_busy_q;
        perf_stall_d = perf_stall_q;
        if (accept) begin
            // The accepting cycle is counted as the first busy cycle.
            perf_busy_d  = 16'd1;
            perf_stall_d = 16'd0;
        end else begin
            if (busy_q && (perf_busy_q != 16'hFFFF)) begin
                perf_busy_d = perf_busy_q + 16'd1;
            end
            if (stall_i && ((state_q == S_FILL) || (state_q == S_WRITE)) &&
                (perf_stall_q != 16'hFFFF)) begin
                perf_stall_d = perf_stall_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_busy_q  <= 16'd0;
            perf_stall_q <= 16'd0;
        end else begin
            perf_busy_q  <= perf_busy_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_busy_cycles_o  = perf_busy_q;
    assign perf_stall_cycles_o = perf_stall_q;
`else
    // Keeps the accept decode referenced when the counters are not built.
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule
